cap_scan_sequencer: RTL and testbench

Time-multiplexed scan controller for four capacitive touch pads. Each pad is charged, released, and timed while it discharges. Each result is compared against a self-calibrating per-channel baseline to produce debounced button states. It sits between the uio pad pins and the uo_out button outputs, and replaces free-running per-pad sensing with one shared, sequenced measurement counter.

---
 rtl/cap_scan_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cap_scan_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_scan_sequencer.sv
// Time-multiplexed capacitive touch scanner for four pads. One shared counter
// times each pad's discharge. A self-calibrating per-channel baseline with
// hysteresis then turns the discharge counts into touch states.
module cap_scan_sequencer #(
   parameter int CHARGE_CYCLES = 16,
   parameter int CNT_W         = 12,
   parameter int MAX_COUNT     = 4095,
   parameter int THRESH        = 32,
   parameter int HYST          = 8,
   parameter int GAP_CYCLES    = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_en,
   input  logic [3:0]       pad_in,
   output logic [3:0]       pad_out,
   output logic [3:0]       pad_oe,
   output logic [3:0]       btn,
   output logic             sample_valid,
   output logic [1:0]       sample_ch,
   output logic [CNT_W-1:0] sample_count,
   output logic             busy
);

   localparam int TMR_MAX = (CHARGE_CYCLES > GAP_CYCLES) ? CHARGE_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int XW      = CNT_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_CHARGE, S_MEASURE, S_EVAL, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [1:0]         ch_q, ch_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   sample_count_q;
   logic [3:0]         sync1_q, sync2_q;
   logic [CNT_W-1:0]   base_q [4];
   logic [3:0]         cal_done_q;
   logic [3:0]         btn_q;

   logic [CNT_W-1:0]   base_cur, base_new;
   logic [XW-1:0]      assert_lvl, release_lvl, count_x;
   logic               btn_new;

   // Two-flop synchroniser for the asynchronous pad levels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pad_in;
         sync2_q <= sync1_q;
      end
   end

   // Sequencer state, channel, shared timer and discharge counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         timer_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         timer_q <= timer_d;
         count_q <= count_d;
      end
   end

   // Next-state logic and pad drive; only the active pad ever leaves ground
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      timer_d = timer_q;
      count_d = count_q;
      pad_out = 4'h0;
      pad_oe  = 4'hF;
      unique case (state_q)
         S_IDLE: begin
            if (scan_en) begin
               state_d = S_CHARGE;
               ch_d    = 2'd0;
               timer_d = '0;
            end
         end
         S_CHARGE: begin
            pad_out[ch_q] = 1'b1;
            if (timer_q == TMR_W'(CHARGE_CYCLES - 1)) begin
               state_d = S_MEASURE;
               count_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_MEASURE: begin
            pad_oe[ch_q] = 1'b0;
            if (sync2_q[ch_q] && (count_q != CNT_W'(MAX_COUNT))) begin
               count_d = count_q + CNT_W'(1);
            end else begin
               state_d = S_EVAL;
            end
         end
         S_EVAL: begin
            timer_d = '0;
            if (!scan_en) begin
               state_d = S_IDLE;
               ch_d    = 2'd0;
            end else if (ch_q == 2'd3) begin
               state_d = S_GAP;
               ch_d    = 2'd0;
            end else begin
               state_d = S_CHARGE;
               ch_d    = ch_q + 2'd1;
            end
         end
         S_GAP: begin
            if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
               timer_d = '0;
               ch_d    = 2'd0;
               state_d = scan_en ? S_CHARGE : S_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Capture the finished count as the measurement hands over to evaluation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample_count_q <= '0;
      end else if (state_q == S_MEASURE && state_d == S_EVAL) begin
         sample_count_q <= count_d;
      end
   end

   // Touch decision with hysteresis; levels are one bit wider so they cannot wrap
   always_comb begin
      base_cur    = base_q[ch_q];
      count_x     = {1'b0, count_q};
      assert_lvl  = {1'b0, base_cur} + XW'(THRESH);
      release_lvl = assert_lvl - XW'(HYST);
      btn_new     = btn_q[ch_q];
      base_new    = base_cur;
      if (!cal_done_q[ch_q]) begin
         base_new = count_q;
      end else begin
         if (!btn_q[ch_q] && (count_x >= assert_lvl)) begin
            btn_new = 1'b1;
         end else if (btn_q[ch_q] && (count_x < release_lvl)) begin
            btn_new = 1'b0;
         end
         // Baseline tracks slow drift only while the pad is untouched
         if (!btn_new) begin
            if (count_q > base_cur) begin
               base_new = base_cur + CNT_W'(1);
            end else if (count_q < base_cur) begin
               base_new = base_cur - CNT_W'(1);
            end
         end
      end
   end

   // Per-channel baseline, calibration flag and button state, updated in EVAL
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            base_q[i] <= '0;
         end
         cal_done_q <= '0;
         btn_q      <= '0;
      end else if (state_q == S_EVAL) begin
         base_q[ch_q]     <= base_new;
         cal_done_q[ch_q] <= 1'b1;
         btn_q[ch_q]      <= btn_new;
      end
   end

   assign btn          = btn_q;
   assign sample_valid = (state_q == S_EVAL);
   assign sample_ch    = ch_q;
   assign sample_count = sample_count_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_cap_scan_sequencer.sv
// Scoreboard bench for cap_scan_sequencer: a pad discharge model drives
// pad_in, expected samples are queued as each scan is set up and compared as
// sample_valid pulses arrive.
module tb_cap_scan_sequencer;

   localparam int CNT_W = 12;

   logic             clk = 1'b0;
   logic             reset;
   logic             scan_en;
   logic [3:0]       pad_in;
   logic [3:0]       pad_out, pad_oe, btn;
   logic             sample_valid;
   logic [1:0]       sample_ch;
   logic [CNT_W-1:0] sample_count;
   logic             busy;

   cap_scan_sequencer #(
      .CHARGE_CYCLES(16), .CNT_W(CNT_W), .MAX_COUNT(4095),
      .THRESH(32), .HYST(8), .GAP_CYCLES(64)
   ) dut (
      .clk(clk), .reset(reset), .scan_en(scan_en), .pad_in(pad_in),
      .pad_out(pad_out), .pad_oe(pad_oe), .btn(btn),
      .sample_valid(sample_valid), .sample_ch(sample_ch),
      .sample_count(sample_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ch;
      int         cnt;
      logic [3:0] btn;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_samples = 0;
   int         dly[4];
   bit         stuck[4];
   int         rel[4];
   int         m_base[4];
   bit         m_cal[4];
   logic [3:0] m_btn;
   bit         btn_pend = 0;
   logic [3:0] btn_exp;
   int         hi_run = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
   endtask

   // Pad model: follows the drive while enabled, stays high dly cycles after release
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pad_oe[i]) begin
            pad_in[i] = pad_out[i];
            rel[i]    = 0;
         end else begin
            rel[i]    = rel[i] + 1;
            pad_in[i] = stuck[i] || (rel[i] <= dly[i]);
         end
      end
   end

   // Monitor: pops the scoreboard on each sample, checks btn one cycle later
   always @(negedge clk) begin
      if (reset) begin
         btn_pend = 0;
         hi_run   = 0;
      end else begin
         if (btn_pend) begin
            chk("btn_after_eval", btn, btn_exp);
            btn_pend = 0;
         end
         if (sample_valid) begin
            n_samples++;
            if (q.size() == 0) begin
               chk("unexpected_sample", 1, 0);
            end else begin
               e = q.pop_front();
               chk("sample_ch", sample_ch, e.ch);
               chk("sample_count", sample_count, e.cnt);
               btn_exp  = e.btn;
               btn_pend = 1;
            end
         end
         if (pad_out != 4'h0) hi_run++;
         else if (hi_run != 0) begin
            chk("charge_len", hi_run, 16);
            hi_run = 0;
         end
      end
   end

   // Reference decision model for one evaluated sample
   task automatic model_eval(input int ch);
      int cnt;
      cnt = stuck[ch] ? 4095 : ((dly[ch] + 2 > 4095) ? 4095 : dly[ch] + 2);
      if (!m_cal[ch]) begin
         m_base[ch] = cnt;
         m_cal[ch]  = 1;
      end else begin
         if (!m_btn[ch] && cnt >= m_base[ch] + 32) m_btn[ch] = 1'b1;
         else if (m_btn[ch] && cnt < m_base[ch] + 24) m_btn[ch] = 1'b0;
         if (!m_btn[ch]) begin
            if (cnt > m_base[ch]) m_base[ch]++;
            else if (cnt < m_base[ch]) m_base[ch]--;
         end
      end
      q.push_back('{ch: ch, cnt: cnt, btn: m_btn});
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_base[i] = 0;
         m_cal[i]  = 0;
      end
      m_btn = 4'h0;
   endtask

   task automatic wait_empty(input string tag);
      int n = 0;
      while (q.size() != 0 && n < 20000) begin
         @(negedge clk); #2;
         n++;
      end
      chk({tag, "_pending"}, q.size(), 0);
   endtask

   task automatic do_scan(input string tag, input int d0, input int d1, input int d2, input int d3);
      dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
      for (int c = 0; c < 4; c++) model_eval(c);
      scan_en = 1'b1;
      wait_empty(tag);
   endtask

   task automatic reset_mid_measure(input string tag);
      int n = 0;
      scan_en = 1'b1;
      while (pad_oe[0] != 1'b0 && n < 200) begin
         @(negedge clk); #2;
         n++;
      end
      chk({tag, "_reach_measure"}, pad_oe[0], 0);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk({tag, "_pad_oe"}, pad_oe, 4'hF);
      chk({tag, "_pad_out"}, pad_out, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_btn"}, btn, 0);
      chk({tag, "_valid"}, sample_valid, 0);
      model_reset();
      scan_en = 1'b0;
      @(negedge clk); #2;
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int ns_before;
      bit busy_dropped;
      reset   = 1'b1;
      scan_en = 1'b0;
      pad_in  = 4'h0;
      for (int i = 0; i < 4; i++) begin
         dly[i] = 20; stuck[i] = 0; rel[i] = 0;
      end
      model_reset();
      repeat (3) @(negedge clk);
      #2;
      chk("rst_pad_oe", pad_oe, 4'hF);
      chk("rst_pad_out", pad_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_btn", btn, 0);
      chk("rst_count", sample_count, 0);
      chk("rst_ch", sample_ch, 0);
      reset = 1'b0;

      // Reset during the first measurement, then a long idle stretch
      reset_mid_measure("rst_mid");
      repeat (100) @(negedge clk);
      #2;
      chk("idle_no_samples", n_samples, 0);
      chk("idle_busy", busy, 0);

      // Calibration scan plus gap length and busy during the gap
      do_scan("cal", 20, 20, 20, 20);
      n = 0;
      busy_dropped = 0;
      while (pad_out == 4'h0 && n < 200) begin
         @(negedge clk); #1;
         n++;
         if (!busy) busy_dropped = 1;
      end
      chk("gap_cycles", n, 65);
      chk("gap_busy", busy_dropped, 0);

      // Touch on channel 2: assert, hold inside hysteresis, release
      do_scan("touch", 20, 20, 60, 20);
      do_scan("hold",  20, 20, 50, 20);
      do_scan("rel",   20, 20, 40, 20);

      // Drift on channel 0, then a count that only clears the undrifted level
      do_scan("drift1", 28, 20, 20, 20);
      do_scan("drift2", 28, 20, 20, 20);
      do_scan("drift3", 28, 20, 20, 20);
      do_scan("drift_chk", 54, 20, 20, 20);

      // Stuck-high pad on channel 1 saturates the counter
      stuck[1] = 1;
      do_scan("timeout", 20, 20, 20, 20);
      stuck[1] = 0;

      // Stop request during channel 1 charge
      dly[0] = 20; dly[1] = 60; dly[2] = 20; dly[3] = 20;
      model_eval(0);
      model_eval(1);
      ns_before = n_samples;
      n = 0;
      while (pad_out[1] != 1'b1 && n < 500) begin
         @(negedge clk); #2;
         n++;
      end
      chk("stop_reach_ch1", pad_out[1], 1);
      scan_en = 1'b0;
      n = 0;
      while (busy && n < 500) begin
         @(negedge clk); #2;
         n++;
      end
      chk("stop_idle", busy, 0);
      chk("stop_queue", q.size(), 0);
      repeat (40) @(negedge clk);
      #2;
      chk("stop_samples", n_samples - ns_before, 2);
      chk("stop_btn_kept", btn, m_btn);

      // Reset loses calibration: the next scan recalibrates
      reset_mid_measure("rst_end");
      do_scan("recal", 60, 60, 60, 60);
      do_scan("post_recal", 60, 60, 60, 60);

      scan_en = 1'b0;
      n = 0;
      while (busy && n < 500) begin
         @(negedge clk); #2;
         n++;
      end
      chk("final_idle", busy, 0);
      chk("final_queue", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
